// File: rtl/caliptra_fpga_apb_initiator.sv
// APB3/APB4 initiator: one register-level request becomes a full SETUP/ACCESS transfer,
// with a PREADY timeout, a held response and a wrapping completed-transfer counter.
module caliptra_fpga_apb_initiator #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int USER_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              aclk_gated,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_prot,
  input  logic [USER_W-1:0] req_user,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [31:0]       xfer_count,
  output logic [ADDR_W-1:0] PADDR,
  output logic [2:0]        PPROT,
  output logic [USER_W-1:0] PAUSER,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam int               CNT_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] WAIT_MAX   = '1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               req_ready_d, rsp_valid_d, rsp_slverr_d, rsp_timeout_d;
  logic [DATA_W-1:0]  rsp_rdata_d, pwdata_d;
  logic [31:0]        xfer_count_d;
  logic [ADDR_W-1:0]  paddr_d;
  logic [2:0]         pprot_d;
  logic [USER_W-1:0]  pauser_d;
  logic               psel_d, penable_d, pwrite_d;

  always_comb begin
    // NOTE: every next value defaults to its current register, so no branch can infer a latch.
    state_d       = state_q;
    wait_d        = wait_q;
    req_ready_d   = req_ready;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_slverr_d  = rsp_slverr;
    rsp_timeout_d = rsp_timeout;
    xfer_count_d  = xfer_count;
    paddr_d       = PADDR;
    pprot_d       = PPROT;
    pauser_d      = PAUSER;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    pwdata_d      = PWDATA;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          pwrite_d    = req_write;
          paddr_d     = req_addr;
          pwdata_d    = req_wdata;
          pprot_d     = req_prot;
          pauser_d    = req_user;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          req_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_rdata_d   = PWRITE ? '0 : PRDATA;
          rsp_slverr_d  = PSLVERR;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          xfer_count_d  = xfer_count + 32'd1;
          state_d       = RESP;
        end else if (TIMEOUT_EN && wait_q == WAIT_LAST) begin
          // Aborted transfers report an error but do not count as completed.
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk_gated or negedge rstn) begin
    if (!rstn) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      state_q     <= IDLE;
      wait_q      <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      xfer_count  <= '0;
      PADDR       <= '0;
      PPROT       <= '0;
      PAUSER      <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_slverr  <= rsp_slverr_d;
      rsp_timeout <= rsp_timeout_d;
      xfer_count  <= xfer_count_d;
      PADDR       <= paddr_d;
      PPROT       <= pprot_d;
      PAUSER      <= pauser_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PWDATA      <= pwdata_d;
    end
  end

endmodule

// File: tb/tb_caliptra_fpga_apb_initiator.sv
// Self-checking bench: transaction-level timeline model of the APB initiator, compared
// against the DUT on every falling edge, plus directed literal checks.
module tb_caliptra_fpga_apb_initiator;

  localparam int T = 8;

  logic        aclk_gated, rstn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata, req_user;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata, xfer_count;
  logic [31:0] PADDR, PAUSER, PWDATA, PRDATA;
  logic [2:0]  PPROT;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  caliptra_fpga_apb_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .aclk_gated(aclk_gated), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_prot(req_prot), .req_user(req_user),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .xfer_count(xfer_count),
    .PADDR(PADDR), .PPROT(PPROT), .PAUSER(PAUSER), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial aclk_gated = 1'b0;
  always #5 aclk_gated = ~aclk_gated;

  int checks = 0;
  int failures = 0;

  // Expected outputs, derived from the transaction timeline in do_txn.
  logic        e_req_ready, e_psel, e_penable, e_rsp_valid, e_slverr, e_timeout, e_write;
  logic [31:0] e_rdata, e_count, e_addr, e_wdata, e_user;
  logic [2:0]  e_prot;

  int          psel_cycles = 0, penable_cycles = 0;
  int          psel_n, penable_n;
  logic [31:0] cap_rdata;
  logic        cap_slverr, cap_timeout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_req_ready = 1'b1; e_psel = 1'b0; e_penable = 1'b0; e_rsp_valid = 1'b0;
    e_slverr = 1'b0; e_timeout = 1'b0; e_write = 1'b0; e_rdata = '0; e_count = '0;
    e_addr = '0; e_wdata = '0; e_user = '0; e_prot = '0;
  endtask

  always @(negedge aclk_gated) begin
    if (PSEL) psel_cycles++;
    if (PENABLE) penable_cycles++;
    check("req_ready", req_ready, e_req_ready);
    check("psel", PSEL, e_psel);
    check("penable", PENABLE, e_penable);
    check("rsp_valid", rsp_valid, e_rsp_valid);
    check("xfer_count", xfer_count, e_count);
    check("paddr", PADDR, e_addr);
    check("pwrite", PWRITE, e_write);
    check("pwdata", PWDATA, e_wdata);
    check("pprot", PPROT, e_prot);
    check("pauser", PAUSER, e_user);
    if (e_rsp_valid) begin
      check("rsp_rdata", rsp_rdata, e_rdata);
      check("rsp_slverr", rsp_slverr, e_slverr);
      check("rsp_timeout", rsp_timeout, e_timeout);
    end
  end

  task automatic scramble_req();
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_prot = 3'($urandom); req_user = $urandom;
  endtask

  task automatic scramble_apb();
    PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
  endtask

  // One transfer: w = responder wait states (w >= T times out), r = cycles rsp_ready stays low.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [2:0] prot, input logic [31:0] user,
                        input bit err, input int w, input int r, input int gap);
    bit to;
    int d_off;
    int psel_base, penable_base;
    to    = (w >= T);
    d_off = 2 + (to ? T - 1 : w);
    for (int g = 0; g < gap; g++) begin
      req_valid = 1'b0; scramble_req(); scramble_apb(); rsp_ready = 1'($urandom);
      @(posedge aclk_gated); #1;
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    req_prot = prot; req_user = user; scramble_apb(); rsp_ready = 1'($urandom);
    psel_base = psel_cycles; penable_base = penable_cycles;
    @(posedge aclk_gated); #1;
    e_req_ready = 1'b0; e_psel = 1'b1; e_penable = 1'b0;
    e_write = wr; e_addr = addr; e_wdata = wdata; e_prot = prot; e_user = user;
    for (int j = 1; j <= d_off; j++) begin
      req_valid = 1'($urandom); scramble_req(); rsp_ready = 1'($urandom);
      if (j < 2) scramble_apb();
      else if (j == d_off && !to) begin PREADY = 1'b1; PRDATA = rdata; PSLVERR = err; end
      else begin PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom); end
      @(posedge aclk_gated); #1;
      if (j == 1) e_penable = 1'b1;
      if (j == d_off) begin
        e_psel = 1'b0; e_penable = 1'b0; e_rsp_valid = 1'b1;
        e_rdata   = (to || wr) ? 32'h0 : rdata;
        e_slverr  = to ? 1'b1 : err;
        e_timeout = to;
        if (!to) e_count = e_count + 32'd1;
      end
    end
    cap_rdata = rsp_rdata; cap_slverr = rsp_slverr; cap_timeout = rsp_timeout;
    for (int k = 0; k <= r; k++) begin
      req_valid = 1'b1; scramble_req(); scramble_apb(); rsp_ready = (k == r);
      @(posedge aclk_gated); #1;
    end
    e_rsp_valid = 1'b0; e_req_ready = 1'b1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    psel_n = psel_cycles - psel_base;
    penable_n = penable_cycles - penable_base;
  endtask

  initial begin
    model_reset();
    rstn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; scramble_req();
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    repeat (3) @(posedge aclk_gated);
    #2;
    check("reset_req_ready", req_ready, 32'd1);
    check("reset_xfer_count", xfer_count, 32'd0);
    check("reset_psel", PSEL, 32'd0);
    rstn = 1'b1;
    @(posedge aclk_gated); #1;

    do_txn(1'b1, 32'h3002_0000, 32'hDEAD_BEEF, 32'h5555_AAAA, 3'd2, 32'h1, 1'b0, 0, 0, 1);
    check("wr_psel_cycles", psel_n, 32'd2);
    check("wr_penable_cycles", penable_n, 32'd1);
    check("wr_rdata", cap_rdata, 32'h0);
    check("wr_slverr", cap_slverr, 32'd0);
    check("wr_count", xfer_count, 32'd1);

    do_txn(1'b0, 32'h3002_0004, 32'h0, 32'h1234_5678, 3'd0, 32'h2, 1'b0, 3, 1, 0);
    check("rd_penable_cycles", penable_n, 32'd4);
    check("rd_rdata", cap_rdata, 32'h1234_5678);
    check("rd_count", xfer_count, 32'd2);

    do_txn(1'b0, 32'h3002_0008, 32'h0, 32'hCAFE_0001, 3'd1, 32'h3, 1'b1, 0, 0, 1);
    check("err_slverr", cap_slverr, 32'd1);
    check("err_timeout", cap_timeout, 32'd0);
    check("err_count", xfer_count, 32'd3);

    do_txn(1'b0, 32'h3002_000C, 32'h0, 32'hFFFF_FFFF, 3'd3, 32'h4, 1'b0, 40, 0, 1);
    check("to_penable_cycles", penable_n, 32'd8);
    check("to_slverr", cap_slverr, 32'd1);
    check("to_timeout", cap_timeout, 32'd1);
    check("to_rdata", cap_rdata, 32'h0);
    check("to_count", xfer_count, 32'd3);

    do_txn(1'b1, 32'h3002_0010, 32'h0BAD_F00D, 32'h0, 3'd4, 32'h5, 1'b0, 1, 10, 0);
    do_txn(1'b0, 32'h3002_0014, 32'h0, 32'h0F0F_0F0F, 3'd5, 32'h6, 1'b0, 0, 0, 0);
    check("b2b_count", xfer_count, 32'd5);

    for (int n = 0; n < 40; n++)
      do_txn(1'($urandom), $urandom, $urandom, $urandom, 3'($urandom), $urandom,
             ($urandom_range(0, 3) == 0), $urandom_range(0, 10), $urandom_range(0, 3),
             $urandom_range(0, 2));

    // Reset while the transfer sits in ACCESS waiting for PREADY.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h3002_0040; req_wdata = 32'h0;
    req_prot = 3'd0; req_user = 32'h7; PREADY = 1'b0;
    @(posedge aclk_gated); #1;
    e_req_ready = 1'b0; e_psel = 1'b1; e_penable = 1'b0; e_write = 1'b0;
    e_addr = 32'h3002_0040; e_wdata = 32'h0; e_prot = 3'd0; e_user = 32'h7;
    req_valid = 1'b0; PREADY = 1'b0;
    @(posedge aclk_gated); #1;
    e_penable = 1'b1;
    repeat (2) begin @(posedge aclk_gated); #1; end
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check("async_psel", PSEL, 32'd0);
    check("async_penable", PENABLE, 32'd0);
    check("async_rsp_valid", rsp_valid, 32'd0);
    check("async_req_ready", req_ready, 32'd1);
    repeat (2) @(posedge aclk_gated);
    #2;
    rstn = 1'b1;
    @(posedge aclk_gated); #1;
    check("post_reset_req_ready", req_ready, 32'd1);
    check("post_reset_count", xfer_count, 32'd0);

    do_txn(1'b1, 32'h3002_0000, 32'h1111_2222, 32'h0, 3'd0, 32'h0, 1'b0, 2, 1, 0);
    check("recover_count", xfer_count, 32'd1);

    repeat (2) @(posedge aclk_gated);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
